// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: CPU request size encodings, the
// memory-side size encoding, the sequencing state type and a byte-count helper.
package lsu_pkg;

  // CPU request size (req_size)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Memory-side size (mem_size)
  localparam logic MEM_SZ_BYTE = 1'b0;
  localparam logic MEM_SZ_WORD = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StCap0,
    StIssue1,
    StCap1,
    StResp
  } lsu_state_t;

  // Bytes touched by an access; the reserved size is flagged separately, so its
  // count only has to be harmless.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational helpers for the load/store unit.
//   Check side : i_chk_size, i_chk_addr -> o_chk_err (reserved size, misalignment,
//                or any touched byte at/above MEM_BYTES).
//   Extend side: i_ext_size, i_ext_signed, i_ext_lo (byte0 of a half load),
//                i_ext_data (memory read data) -> o_ext_data (assembled and
//                sign/zero-extended load result).
module lsu_align #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic [1:0]        i_chk_size,
  input  logic [ADDR_W-1:0] i_chk_addr,
  output logic              o_chk_err,
  input  logic [1:0]        i_ext_size,
  input  logic              i_ext_signed,
  input  logic [7:0]        i_ext_lo,
  input  logic [31:0]       i_ext_data,
  output logic [31:0]       o_ext_data
);
  import lsu_pkg::*;

  localparam int unsigned AddrW1 = ADDR_W + 1;

  // One extra bit so the last-byte address cannot wrap below MEM_BYTES.
  logic [ADDR_W:0] w_last;
  logic            w_range_err;
  logic            w_align_err;

  assign w_last      = {1'b0, i_chk_addr} + AddrW1'(nbytes(i_chk_size) - 3'd1);
  assign w_range_err = (w_last >= AddrW1'(MEM_BYTES));
  assign w_align_err = ((i_chk_size == SZ_HALF) && i_chk_addr[0]) ||
                       ((i_chk_size == SZ_WORD) && (i_chk_addr[1:0] != 2'b00));
  assign o_chk_err   = (i_chk_size == SZ_RSVD) || w_align_err || w_range_err;

  // Byte-mode reads only guarantee bits [7:0]; upper bits are ignored.
  // For a half load, i_ext_data carries byte1 and i_ext_lo holds byte0.
  always_comb begin
    o_ext_data = i_ext_data;
    case (i_ext_size)
      SZ_BYTE: o_ext_data = {{24{i_ext_signed & i_ext_data[7]}}, i_ext_data[7:0]};
      SZ_HALF: o_ext_data = {{16{i_ext_signed & i_ext_data[7]}}, i_ext_data[7:0], i_ext_lo};
      default: o_ext_data = i_ext_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU load/store over valid/ready, sequences the
// byte-addressed data-memory strobes (halfwords as two byte accesses), and
// returns extended load data with an error flag.
//   CPU side   : req_valid/req_ready, req_wr, req_size, req_signed, req_addr,
//                req_wdata; resp_valid/resp_ready, resp_rdata, resp_err.
//   Memory side: mem_address, mem_write_data, mem_rd, mem_wr, mem_size (all
//                registered), mem_read_data (valid the cycle after mem_rd).
module load_store_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_size,
  input  logic [31:0]       mem_read_data
);
  import lsu_pkg::*;

  lsu_state_t        r_state, w_state_next;
  logic              r_wr, w_wr_next;
  logic [1:0]        r_size, w_size_next;
  logic              r_signed, w_signed_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [31:0]       r_wdata, w_wdata_next;
  logic [7:0]        r_lo, w_lo_next;
  logic [31:0]       r_rdata, w_rdata_next;
  logic              r_err, w_err_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [31:0]       r_mem_wdata, w_mem_wdata_next;
  logic              r_mem_rd, w_mem_rd_next;
  logic              r_mem_wr, w_mem_wr_next;
  logic              r_mem_size, w_mem_size_next;

  logic              w_chk_err;
  logic [31:0]       w_ext_data;

  lsu_align #(
    .ADDR_W   (ADDR_W),
    .MEM_BYTES(MEM_BYTES)
  ) u_align (
    .i_chk_size  (req_size),
    .i_chk_addr  (req_addr),
    .o_chk_err   (w_chk_err),
    .i_ext_size  (r_size),
    .i_ext_signed(r_signed),
    .i_ext_lo    (r_lo),
    .i_ext_data  (mem_read_data),
    .o_ext_data  (w_ext_data)
  );

  always_comb begin
    w_state_next     = r_state;
    w_wr_next        = r_wr;
    w_size_next      = r_size;
    w_signed_next    = r_signed;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_lo_next        = r_lo;
    w_rdata_next     = r_rdata;
    w_err_next       = r_err;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_rd_next    = 1'b0;
    w_mem_wr_next    = 1'b0;
    w_mem_size_next  = MEM_SZ_BYTE;

    case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_wr_next     = req_wr;
          w_size_next   = req_size;
          w_signed_next = req_signed;
          w_addr_next   = req_addr;
          w_wdata_next  = req_wdata;
          w_err_next    = w_chk_err;
          w_rdata_next  = '0;
          if (w_chk_err) begin
            w_state_next = StResp;
          end else begin
            // First access is launched from the accept edge so it is live in cycle 1.
            w_state_next    = StIssue0;
            w_mem_rd_next   = ~req_wr;
            w_mem_wr_next   = req_wr;
            w_mem_addr_next = req_addr;
            if (req_size == SZ_WORD) begin
              w_mem_size_next  = MEM_SZ_WORD;
              w_mem_wdata_next = req_wdata;
            end else begin
              w_mem_wdata_next = {24'h0, req_wdata[7:0]};
            end
          end
        end
      end
      StIssue0: begin
        if (!r_wr) begin
          w_state_next = StCap0;
        end else if (r_size == SZ_HALF) begin
          w_state_next     = StIssue1;
          w_mem_wr_next    = 1'b1;
          w_mem_addr_next  = r_addr + ADDR_W'(1);
          w_mem_wdata_next = {24'h0, r_wdata[15:8]};
        end else begin
          w_state_next = StResp;
        end
      end
      StCap0: begin
        if (r_size == SZ_HALF) begin
          w_lo_next       = mem_read_data[7:0];
          w_state_next    = StIssue1;
          w_mem_rd_next   = 1'b1;
          w_mem_addr_next = r_addr + ADDR_W'(1);
        end else begin
          w_rdata_next = w_ext_data;
          w_state_next = StResp;
        end
      end
      StIssue1: begin
        w_state_next = r_wr ? StResp : StCap1;
      end
      StCap1: begin
        w_rdata_next = w_ext_data;
        w_state_next = StResp;
      end
      StResp: begin
        if (resp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wr        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lo        <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_size  <= MEM_SZ_BYTE;
    end else begin
      r_state     <= w_state_next;
      r_wr        <= w_wr_next;
      r_size      <= w_size_next;
      r_signed    <= w_signed_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_lo        <= w_lo_next;
      r_rdata     <= w_rdata_next;
      r_err       <= w_err_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_rd    <= w_mem_rd_next;
      r_mem_wr    <= w_mem_wr_next;
      r_mem_size  <= w_mem_size_next;
    end
  end

  assign req_ready      = (r_state == StIdle);
  assign resp_valid     = (r_state == StResp);
  assign resp_rdata     = r_rdata;
  assign resp_err       = r_err;
  assign mem_address    = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign mem_size       = r_mem_size;
  // Reset masks the strobes in the cycle it is asserted so an aborted access
  // never lands in memory at the reset edge.
  assign mem_rd         = r_mem_rd & ~rst;
  assign mem_wr         = r_mem_wr & ~rst;

endmodule
